// File: rtl/control_unit_pipe_if.sv
// Bus between the pipelined control unit and its datapath/hazard logic.
// The slave modport is the control unit; the master modport drives it.
// Optional performance counters appear when PERF_COUNT_EN is defined.
interface control_unit_pipe_if;
    logic       enable;
    logic       startProcess;
    logic [6:0] opCode;
    logic       stall;
    logic       flush;

    logic       running;
    logic       endProcess;
    logic       error;
    logic       jump;
    logic       jumpReg;
    logic       branch;
    logic [1:0] aluSrc1;
    logic [1:0] aluSrc2;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regWrite;
`ifdef PERF_COUNT_EN
    logic [31:0] retired;
    logic [31:0] bubbles;
`endif

    modport slave (
        input  enable, startProcess, opCode, stall, flush,
`ifdef PERF_COUNT_EN
        output retired, bubbles,
`endif
        output running, endProcess, error, jump, jumpReg, branch,
        output aluSrc1, aluSrc2, aluOp, memRead, memWrite, memtoReg, regWrite
    );

    modport master (
        output enable, startProcess, opCode, stall, flush,
`ifdef PERF_COUNT_EN
        input  retired, bubbles,
`endif
        input  running, endProcess, error, jump, jumpReg, branch,
        input  aluSrc1, aluSrc2, aluOp, memRead, memWrite, memtoReg, regWrite
    );
endinterface

// File: rtl/control_unit_pipe.sv
// Pipelined RISC-V control unit: combinational ID-stage decode, MEM/WB
// control delay lines, and the start/drain/done/error program FSM.
// Optional feature macro: PERF_COUNT_EN adds retired/bubbles counters.
// WB_DLY must be >= MEM_DLY and MEM_DLY must lie in 1..4.
module control_unit_pipe #(
    parameter int unsigned MEM_DLY    = 1,
    parameter int unsigned WB_DLY     = 2,
    parameter logic [6:0]  END_OPCODE = 7'b1110011
) (
    input  logic               clk,
    input  logic               rstN,
    control_unit_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERROR
    } state_t;

    typedef struct packed {
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic [1:0] src1;
        logic [1:0] src2;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [6:0] OP_LTYPE = 7'b0000011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_STYPE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JTYPE = 7'b1101111;

    localparam logic [1:0] SRC1_REG  = 2'b00;
    localparam logic [1:0] SRC1_PC   = 2'b01;
    localparam logic [1:0] SRC1_ZERO = 2'b10;
    localparam logic [1:0] SRC2_REG  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] SRC2_FOUR = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    localparam int unsigned CNT_W = $clog2(WB_DLY + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    ctrl_t            w_dec;
    ctrl_t            w_id;
    logic             w_known;
    logic             w_is_end;
    logic             w_run;
    logic             w_issue;
    logic             w_start;
    logic [1:0]       w_mem_ld;
    logic [1:0]       w_wb_ld;
    logic [1:0]       r_mem_dly [MEM_DLY];
    logic [1:0]       r_wb_dly  [WB_DLY];
    logic [CNT_W-1:0] r_drain_cnt;

    assign w_run    = (r_state == S_RUN);
    assign w_is_end = (bus.opCode == END_OPCODE);
    // An instruction only leaves ID when it is neither squashed nor held.
    assign w_issue  = w_run & ~bus.flush & ~bus.stall;
    assign w_start  = bus.enable & bus.startProcess &
                      (r_state inside {S_IDLE, S_DONE, S_ERROR});

    // Opcode decode into the full control word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_dec   = '0;
        w_known = 1'b0;
        if (w_is_end) begin
            w_known = 1'b1;
        end else begin
            case (bus.opCode)
                OP_LTYPE: begin
                    w_known = 1'b1; w_dec.mem_read = 1'b1; w_dec.mem_to_reg = 1'b1;
                    w_dec.reg_write = 1'b1; w_dec.src1 = SRC1_REG; w_dec.src2 = SRC2_IMM;
                    w_dec.alu_op = ALU_ADD;
                end
                OP_ITYPE: begin
                    w_known = 1'b1; w_dec.reg_write = 1'b1; w_dec.src1 = SRC1_REG;
                    w_dec.src2 = SRC2_IMM; w_dec.alu_op = ALU_ITYPE;
                end
                OP_AUIPC: begin
                    w_known = 1'b1; w_dec.reg_write = 1'b1; w_dec.src1 = SRC1_PC;
                    w_dec.src2 = SRC2_IMM; w_dec.alu_op = ALU_ADD;
                end
                OP_STYPE: begin
                    w_known = 1'b1; w_dec.mem_write = 1'b1; w_dec.src1 = SRC1_REG;
                    w_dec.src2 = SRC2_IMM; w_dec.alu_op = ALU_ADD;
                end
                OP_RTYPE: begin
                    w_known = 1'b1; w_dec.reg_write = 1'b1; w_dec.src1 = SRC1_REG;
                    w_dec.src2 = SRC2_REG; w_dec.alu_op = ALU_RTYPE;
                end
                OP_LUI: begin
                    w_known = 1'b1; w_dec.reg_write = 1'b1; w_dec.src1 = SRC1_ZERO;
                    w_dec.src2 = SRC2_IMM; w_dec.alu_op = ALU_ADD;
                end
                OP_BTYPE: begin
                    w_known = 1'b1; w_dec.branch = 1'b1; w_dec.src1 = SRC1_REG;
                    w_dec.src2 = SRC2_REG; w_dec.alu_op = ALU_BRANCH;
                end
                OP_JALR: begin
                    w_known = 1'b1; w_dec.jump = 1'b1; w_dec.jump_reg = 1'b1;
                    w_dec.reg_write = 1'b1; w_dec.src1 = SRC1_PC; w_dec.src2 = SRC2_FOUR;
                    w_dec.alu_op = ALU_ADD;
                end
                OP_JTYPE: begin
                    w_known = 1'b1; w_dec.jump = 1'b1; w_dec.reg_write = 1'b1;
                    w_dec.src1 = SRC1_PC; w_dec.src2 = SRC2_FOUR; w_dec.alu_op = ALU_ADD;
                end
                default: ;
            endcase
        end
    end

    // ID controls are shown during a stall but vanish when squashed or not running.
    assign w_id     = (w_run & ~bus.flush) ? w_dec : '0;
    assign w_mem_ld = w_issue ? {w_dec.mem_read, w_dec.mem_write}  : 2'b00;
    assign w_wb_ld  = w_issue ? {w_dec.mem_to_reg, w_dec.reg_write} : 2'b00;

    // Program FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.startProcess) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.stall && !bus.flush) begin
                    if (w_is_end)      w_state_nxt = S_DRAIN;
                    else if (!w_known) w_state_nxt = S_ERROR;
                end
            end
            // The edge that takes the counter from 1 to 0 is the last drain cycle.
            S_DRAIN: begin
                if (r_drain_cnt <= CNT_W'(1)) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Program FSM state register, frozen while enable is low.
    always_ff @(posedge clk or negedge rstN) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstN)           r_state <= S_IDLE;
        else if (bus.enable) r_state <= w_state_nxt;
    end

    // Drain counter: loaded on entry to DRAIN, counts enabled cycles down.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_drain_cnt <= '0;
        end else if (bus.enable) begin
            if (w_run && w_state_nxt == S_DRAIN)
                r_drain_cnt <= CNT_W'(WB_DLY);
            else if (r_state == S_DRAIN && r_drain_cnt != '0)
                r_drain_cnt <= r_drain_cnt - CNT_W'(1);
        end
    end

    // MEM and WB control delay lines; a program start flushes anything in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            // NOTE: these shift stages are control state, not bulk storage, so each one is reset.
            for (int i = 0; i < MEM_DLY; i++) r_mem_dly[i] <= '0;
            for (int i = 0; i < WB_DLY; i++)  r_wb_dly[i]  <= '0;
        end else if (bus.enable) begin
            if (w_start) begin
                for (int i = 0; i < MEM_DLY; i++) r_mem_dly[i] <= '0;
                for (int i = 0; i < WB_DLY; i++)  r_wb_dly[i]  <= '0;
            end else begin
                r_mem_dly[0] <= w_mem_ld;
                r_wb_dly[0]  <= w_wb_ld;
                for (int i = 1; i < MEM_DLY; i++) r_mem_dly[i] <= r_mem_dly[i-1];
                for (int i = 1; i < WB_DLY; i++)  r_wb_dly[i]  <= r_wb_dly[i-1];
            end
        end
    end

`ifdef PERF_COUNT_EN
    logic        w_retire;
    logic        w_bubble;
    logic [31:0] r_retired;
    logic [31:0] r_bubbles;

    assign w_retire = bus.enable & (r_wb_dly[WB_DLY-1] != 2'b00);
    assign w_bubble = bus.enable & w_run & (bus.stall | bus.flush);

    // Retired-instruction and forced-bubble counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_retired <= '0;
            r_bubbles <= '0;
        end else if (w_start) begin
            r_retired <= '0;
            r_bubbles <= '0;
        end else begin
            if (w_retire) r_retired <= r_retired + 32'd1;
            if (w_bubble) r_bubbles <= r_bubbles + 32'd1;
        end
    end

    assign bus.retired = r_retired;
    assign bus.bubbles = r_bubbles;
`endif

    assign bus.running    = w_run;
    assign bus.endProcess = (r_state == S_DONE);
    assign bus.error      = (r_state == S_ERROR);
    assign bus.jump       = w_id.jump;
    assign bus.jumpReg    = w_id.jump_reg;
    assign bus.branch     = w_id.branch;
    assign bus.aluSrc1    = w_id.src1;
    assign bus.aluSrc2    = w_id.src2;
    assign bus.aluOp      = w_id.alu_op;
    assign bus.memRead    = r_mem_dly[MEM_DLY-1][1];
    assign bus.memWrite   = r_mem_dly[MEM_DLY-1][0];
    assign bus.memtoReg   = r_wb_dly[WB_DLY-1][1];
    assign bus.regWrite   = r_wb_dly[WB_DLY-1][0];
endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench for control_unit_pipe: reference decode table, small
// program-state model and MEM/WB scoreboards fed as stimulus is driven.
module tb_control_unit_pipe;
    localparam int unsigned MEM_DLY = 1;
    localparam int unsigned WB_DLY  = 2;
    localparam logic [6:0] END_OP  = 7'b1110011;
    localparam logic [6:0] LTYPE   = 7'b0000011;
    localparam logic [6:0] ITYPE   = 7'b0010011;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] STYPE   = 7'b0100011;
    localparam logic [6:0] RTYPE   = 7'b0110011;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] BTYPE   = 7'b1100011;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] JTYPE   = 7'b1101111;
    localparam logic [6:0] BADOP   = 7'b1111111;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE, M_ERROR} mstate_t;

    // {jump, jumpReg, branch, src1, src2, aluOp} and {memRead, memWrite, memtoReg, regWrite}
    typedef struct packed {
        logic [8:0] id;
        logic [1:0] mem;
        logic [1:0] wb;
    } exp_t;

    logic clk;
    logic rstN;
    control_unit_pipe_if bus ();

    control_unit_pipe #(.MEM_DLY(MEM_DLY), .WB_DLY(WB_DLY), .END_OPCODE(END_OP)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    mstate_t    m_state;
    int         m_drain;
    logic [1:0] q_mem [$];
    logic [1:0] q_wb  [$];
    logic [1:0] exp_mem;
    logic [1:0] exp_wb;
    int unsigned m_retired;
    int unsigned m_bubbles;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "bench watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic exp_t decode(input logic [6:0] op);
        exp_t e;
        e = '0;
        case (op)
            LTYPE: begin e.id = {3'b000, 2'b00, 2'b01, 2'b00}; e.mem = 2'b10; e.wb = 2'b11; end
            ITYPE: begin e.id = {3'b000, 2'b00, 2'b01, 2'b11}; e.wb = 2'b01; end
            AUIPC: begin e.id = {3'b000, 2'b01, 2'b01, 2'b00}; e.wb = 2'b01; end
            STYPE: begin e.id = {3'b000, 2'b00, 2'b01, 2'b00}; e.mem = 2'b01; end
            RTYPE: begin e.id = {3'b000, 2'b00, 2'b00, 2'b10}; e.wb = 2'b01; end
            LUI:   begin e.id = {3'b000, 2'b10, 2'b01, 2'b00}; e.wb = 2'b01; end
            BTYPE: begin e.id = {3'b001, 2'b00, 2'b00, 2'b01}; end
            JALR:  begin e.id = {3'b110, 2'b01, 2'b10, 2'b00}; e.wb = 2'b01; end
            JTYPE: begin e.id = {3'b100, 2'b01, 2'b10, 2'b00}; e.wb = 2'b01; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic is_known(input logic [6:0] op);
        return op inside {LTYPE, ITYPE, AUIPC, STYPE, RTYPE, LUI, BTYPE, JALR, JTYPE, END_OP};
    endfunction

    task automatic init_queues();
        q_mem.delete();
        q_wb.delete();
        for (int i = 1; i < MEM_DLY; i++) q_mem.push_back(2'b00);
        for (int i = 1; i < WB_DLY; i++)  q_wb.push_back(2'b00);
        exp_mem = 2'b00;
        exp_wb  = 2'b00;
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_drain   = 0;
        m_retired = 0;
        m_bubbles = 0;
        init_queues();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_status"}, 32'({bus.running, bus.endProcess, bus.error}),
              32'({m_state == M_RUN, m_state == M_DONE, m_state == M_ERROR}));
        check({tag, "_mem"}, 32'({bus.memRead, bus.memWrite}), 32'(exp_mem));
        check({tag, "_wb"},  32'({bus.memtoReg, bus.regWrite}), 32'(exp_wb));
`ifdef PERF_COUNT_EN
        check({tag, "_retired"}, bus.retired, m_retired);
        check({tag, "_bubbles"}, bus.bubbles, m_bubbles);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({bus.running, bus.endProcess, bus.error, bus.jump, bus.jumpReg,
                        bus.branch, bus.aluSrc1, bus.aluSrc2, bus.aluOp, bus.memRead,
                        bus.memWrite, bus.memtoReg, bus.regWrite}), 32'd0);
`ifdef PERF_COUNT_EN
        check({tag, "_perf"}, bus.retired | bus.bubbles, 32'd0);
`endif
    endtask

    // One clock of stimulus: check ID decode, push expectations, check after the edge.
    task automatic step(input string tag, input logic en, input logic st,
                        input logic [6:0] op, input logic stl, input logic fl);
        exp_t e;
        exp_t id_e;
        logic [1:0] ld_mem;
        logic [1:0] ld_wb;
        logic start_edge;
        @(negedge clk);
        bus.enable       = en;
        bus.startProcess = st;
        bus.opCode       = op;
        bus.stall        = stl;
        bus.flush        = fl;
        #1;
        e    = decode(op);
        id_e = (m_state == M_RUN && !fl) ? e : '0;
        check({tag, "_id"}, 32'({bus.jump, bus.jumpReg, bus.branch, bus.aluSrc1,
                                 bus.aluSrc2, bus.aluOp}), 32'(id_e.id));
        ld_mem = (m_state == M_RUN && !stl && !fl) ? e.mem : 2'b00;
        ld_wb  = (m_state == M_RUN && !stl && !fl) ? e.wb  : 2'b00;
        start_edge = en && st && (m_state inside {M_IDLE, M_DONE, M_ERROR});
        if (en) begin
            if (start_edge) begin
                m_retired = 0;
                m_bubbles = 0;
            end else begin
                if (exp_wb != 2'b00) m_retired++;
                if (m_state == M_RUN && (stl || fl)) m_bubbles++;
            end
            case (m_state)
                M_IDLE, M_DONE, M_ERROR: if (st) m_state = M_RUN;
                M_RUN: begin
                    if (!stl && !fl) begin
                        if (op == END_OP) begin
                            m_state = M_DRAIN;
                            m_drain = WB_DLY;
                        end else if (!is_known(op)) begin
                            m_state = M_ERROR;
                        end
                    end
                end
                M_DRAIN: begin
                    m_drain--;
                    if (m_drain == 0) m_state = M_DONE;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        if (en) begin
            if (start_edge) init_queues();
            q_mem.push_back(ld_mem);
            q_wb.push_back(ld_wb);
            if (q_mem.size() >= MEM_DLY) exp_mem = q_mem.pop_front();
            if (q_wb.size() >= WB_DLY)   exp_wb  = q_wb.pop_front();
        end
        check_status(tag);
    endtask

    initial begin
        rstN             = 1'b0;
        bus.enable       = 1'b0;
        bus.startProcess = 1'b0;
        bus.opCode       = 7'd0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rstN = 1'b1;

        // IDLE holds without a start; then start and run LTYPE followed by ITYPE.
        step("idle_hold", 1, 0, ITYPE, 0, 0);
        step("start",     1, 1, ITYPE, 0, 0);
        step("ltype",     1, 0, LTYPE, 0, 0);
        check("ltype_memread_1cyc", 32'(bus.memRead), 32'd1);
        step("itype",     1, 0, ITYPE, 0, 0);
        check("ltype_wb_2cyc", 32'({bus.memtoReg, bus.regWrite}), 32'd3);
        step("rtype_stall0", 1, 0, RTYPE, 1, 0);
        check("itype_wb", 32'({bus.memtoReg, bus.regWrite}), 32'd1);
        step("rtype_stall1", 1, 0, RTYPE, 1, 0);
        step("rtype_go",     1, 0, RTYPE, 0, 0);
        step("flush_stall",  1, 0, ITYPE, 1, 1);
        step("auipc", 1, 0, AUIPC, 0, 0);
        step("stype", 1, 0, STYPE, 0, 0);
        step("lui",   1, 0, LUI,   0, 0);
        step("btype", 1, 0, BTYPE, 0, 0);
        step("jalr",  1, 0, JALR,  0, 0);
        step("jtype", 1, 0, JTYPE, 0, 0);
        step("flush", 1, 0, JTYPE, 0, 1);
        step("hold0", 0, 0, LTYPE, 0, 0);
        step("hold1", 0, 1, LTYPE, 1, 0);
        step("ltype2", 1, 0, LTYPE, 0, 0);

        // Asynchronous reset with a load in flight.
        #2;
        rstN = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rstN = 1'b1;
        step("post_reset_idle", 1, 0, LTYPE, 0, 0);
        step("restart",         1, 1, ITYPE, 0, 0);

        // Illegal opcode: ignored while stalled or flushed, sticky error otherwise.
        step("jtype_pre_err", 1, 0, JTYPE, 0, 0);
        step("bad_stalled",   1, 0, BADOP, 1, 0);
        step("bad_flushed",   1, 0, BADOP, 0, 1);
        step("bad",           1, 0, BADOP, 0, 0);
        check("error_set", 32'(bus.error), 32'd1);
        step("err_drain0",    1, 0, ITYPE, 0, 0);
        step("err_drain1",    1, 0, ITYPE, 0, 0);
        step("err_start",     1, 1, ITYPE, 0, 0);
        check("error_cleared", 32'({bus.running, bus.error}), 32'd2);

        // END_OPCODE after a store; enable gaps stretch the drain.
        step("stype_pre_end", 1, 0, STYPE, 0, 0);
        step("end_flushed",   1, 0, END_OP, 0, 1);
        step("end",           1, 0, END_OP, 0, 0);
        step("drain_hold0",   0, 0, END_OP, 0, 0);
        step("drain_hold1",   0, 0, END_OP, 0, 0);
        step("drain0",        1, 0, ITYPE, 0, 0);
        check("not_done_yet", 32'(bus.endProcess), 32'd0);
        step("drain1",        1, 0, ITYPE, 0, 0);
        check("done_after_drain", 32'(bus.endProcess), 32'd1);
        step("done_hold",     1, 0, ITYPE, 0, 0);

        // Short program from DONE for retire/bubble accounting.
        step("start_done", 1, 1, ITYPE, 0, 0);
        step("p_itype",    1, 0, ITYPE, 0, 0);
        step("p_btype",    1, 0, BTYPE, 0, 0);
        step("p_rtype",    1, 0, RTYPE, 0, 0);
        step("p_stall",    1, 0, END_OP, 1, 0);
        step("p_end",      1, 0, END_OP, 0, 0);
        step("p_drain0",   1, 0, ITYPE, 0, 0);
        step("p_drain1",   1, 0, ITYPE, 0, 0);
        check("p_done", 32'(bus.endProcess), 32'd1);
`ifdef PERF_COUNT_EN
        check("p_retired_2", bus.retired, 32'd2);
        check("p_bubbles_1", bus.bubbles, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
Pipelined successor to the single-cycle RISC-V control unit. It decodes the 7-bit opcode in ID and drives ID-stage controls combinationally. It carries memory and writeback controls through parametrised delay lines that track the datapath's MEM and WB stages. It owns the program start/drain/end/error state machine, handles stall and flush from the hazard unit, and flags illegal opcodes.

Parameters:
MEM_DLY, 1, registered cycles from ID to MEM-stage controls (memRead, memWrite); legal range 1..4
WB_DLY, 2, registered cycles from ID to WB-stage controls (memtoReg, regWrite); must satisfy WB_DLY >= MEM_DLY
END_OPCODE, 7'b1110011, opcode that terminates the program (SYSTEM/ECALL)

Ports:
clk  in  1  system clock, all state on rising edge
rstN  in  1  asynchronous active-low reset
enable  in  1  global advance; 0 freezes every register and the FSM
startProcess  in  1  start request, sampled in IDLE, DONE and ERROR
opCode  in  7  instruction opcode of the ID-stage instruction
stall  in  1  hazard stall: hold ID and insert a bubble downstream
flush  in  1  squash the ID-stage instruction (taken branch or jump)
running  out  1  FSM is in RUN
endProcess  out  1  program completed and pipeline drained
error  out  1  illegal opcode seen, sticky
jump, jumpReg, branch  out  1 each  ID-stage controls
aluSrc1, aluSrc2  out  2 each  ALU operand selects: src1 00=REG 01=PC 10=ZERO; src2 00=REG 01=IMM 10=FOUR
aluOp  out  2  00=ADD 01=BRANCH 10=RTYPE 11=ITYPE
memRead, memWrite  out  1 each  MEM-stage controls, delayed MEM_DLY
memtoReg, regWrite  out  1 each  WB-stage controls, delayed WB_DLY

Behaviour:
- Reset (rstN=0, any time, asynchronous): FSM=IDLE; all delay-line registers 0; every output 0.
- FSM states:
  - IDLE -> RUN on enable & startProcess.
  - RUN -> ERROR on decode of an unknown opcode (not stalled, not flushed).
  - RUN -> DRAIN on decode of END_OPCODE (not stalled, not flushed).
  - DRAIN: counter loads WB_DLY and decrements while enable=1; at 0 -> DONE.
  - DONE: endProcess=1, held.
  - ERROR: error=1, held; in-flight stages keep draining.
  - DONE/ERROR -> RUN on enable & startProcess; delay lines and flags are cleared on that edge.
- Decode, valid only in RUN with flush=0; otherwise ID controls are all 0:
  - LTYPE 0000011: memRead, memtoReg, regWrite; src1=REG, src2=IMM, aluOp=ADD
  - ITYPE 0010011: regWrite; src1=REG, src2=IMM, aluOp=ITYPE
  - AUIPC 0010111: regWrite; src1=PC, src2=IMM, aluOp=ADD
  - STYPE 0100011: memWrite; src1=REG, src2=IMM, aluOp=ADD
  - RTYPE 0110011: regWrite; src1=REG, src2=REG, aluOp=RTYPE
  - LUI 0110111: regWrite; src1=ZERO, src2=IMM, aluOp=ADD
  - BTYPE 1100011: branch; src1=REG, src2=REG, aluOp=BRANCH
  - JALR 1100111: jump, jumpReg, regWrite; src1=PC, src2=FOUR, aluOp=ADD
  - JTYPE 1101111: jump, regWrite; src1=PC, src2=FOUR, aluOp=ADD
  - END_OPCODE: all controls 0
  - Unknown opcode: all controls 0
- Delay lines advance only when enable=1. Stage 1 loads decoded MEM/WB bits, or 0 when stall, flush, or state != RUN. Later stages shift unconditionally.
- Priority: flush > stall. flush=1 with stall=1 yields a bubble and no FSM transition.
- enable=0: nothing changes; outputs hold their current registered and decoded values.

Optional Feature:
PERF_COUNT_EN
- Defined: adds output retired[31:0] and bubbles[31:0].
  - retired increments when a non-zero WB control word leaves the last WB_DLY stage.
  - bubbles increments on each enabled cycle where stall|flush forced a stage-1 bubble.
  - Both reset to 0 asynchronously and clear on a start from DONE/ERROR; both wrap at 2^32.
- Undefined: neither port nor its counters exist; all other behaviour identical.

Test Plan:
- Reset mid-RUN with LTYPE in flight -> all outputs 0 immediately, IDLE; startProcess needed to resume.
- start, opCode=LTYPE for one cycle then ITYPE -> memRead=1 exactly 1 cycle later; memtoReg=1 and regWrite=1 exactly 2 cycles later; ITYPE regWrite the following cycle.
- RTYPE with stall=1 for 2 cycles -> aluOp=10 held; two zero bubbles then one regWrite pulse in WB; flush+stall together -> bubble only.
- opCode=7'b1111111 in RUN -> error=1 next edge, ID controls 0, prior JTYPE regWrite still reaches WB; startProcess -> RUN, error=0.
- opCode=END_OPCODE after STYPE -> running=0, endProcess rises after WB_DLY=2 enabled cycles; enable=0 during DRAIN extends it exactly by the held cycles.
- PERF_COUNT_EN, program ITYPE,BTYPE,RTYPE,stall,END -> retired=2, bubbles=1 at DONE.
